// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default sizing.
package dmem_pkg;

  localparam int DMEM_BYTES_DEF = 4096;
  localparam int DMEM_WAIT_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-organised data memory: synchronous big-endian 32-bit write, combinational read.
module dmem_array #(
  parameter int MEM_BYTES = 4096,
  parameter int AW        = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  // Contents are deliberately not reset so data survives a controller reset.
  logic [7:0] mem_q [MEM_BYTES];

  logic [AW-1:0] addr1, addr2, addr3;

  assign addr1 = addr_i + AW'(1);
  assign addr2 = addr_i + AW'(2);
  assign addr3 = addr_i + AW'(3);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i[31:24];
      mem_q[addr1]  <= wdata_i[23:16];
      mem_q[addr2]  <= wdata_i[15:8];
      mem_q[addr3]  <= wdata_i[7:0];
    end
  end

  assign rdata_o = {mem_q[addr_i], mem_q[addr1], mem_q[addr2], mem_q[addr3]};

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: request latch, wait-state timer, error decode and bus tri-state control.
// state | meaning
// IDLE  | waiting for a chip-select with a read or write strobe
// WAIT  | counting wait states; dropping chip-select aborts
// XFER  | single transfer cycle, dm_rdy high, write commits at its end
// HOLD  | transfer done, read data held while dm_rd stays high, until chip-select drops
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES   = DMEM_BYTES_DEF,
  parameter int WAIT_STATES = DMEM_WAIT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        dm_cs,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] Mem_addr,
  inout  wire  [31:0] Bus_data,
  output logic        dm_rdy,
  output logic        dm_err
);

  localparam int         AW        = $clog2(MEM_BYTES);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;

  logic          req_single, req_dual, bad_addr;
  logic [32:0]   addr_end;
  logic          mem_we, bus_oe;
  logic [31:0]   arr_rdata, rd_data;

  assign req_single = dm_cs & (dm_rd ^ dm_wr);
  assign req_dual   = dm_cs & dm_rd & dm_wr;
  assign addr_end   = {1'b0, Mem_addr} + 33'd3;
  assign bad_addr   = (Mem_addr[1:0] != 2'b00) || (addr_end >= 33'(MEM_BYTES));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_dual) begin
          // Conflicting strobes skip the wait and never touch memory.
          state_d = ST_XFER;
          cnt_d   = 4'd0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end else if (req_single) begin
          addr_d  = Mem_addr[AW-1:0];
          rd_d    = dm_rd;
          wr_d    = dm_wr;
          err_d   = bad_addr;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES == 0) ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!dm_cs) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_XFER: state_d = ST_HOLD;
      ST_HOLD: if (!dm_cs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dm_rdy  = (state_q == ST_XFER);
  assign dm_err  = dm_rdy & err_q;
  assign mem_we  = dm_rdy & wr_q & ~err_q;
  assign rd_data = err_q ? 32'h0 : arr_rdata;
  assign bus_oe  = rd_q & ((state_q == ST_XFER) | ((state_q == ST_HOLD) & dm_rd));

  assign Bus_data = bus_oe ? rd_data : 'z;

  dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (Bus_data),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: a 2-wait-state instance and a 0-wait-state instance.
module tb_data_mem_resp;

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0;
  logic        sel0 = 1'b0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_dout = '0;

  tri1  [31:0] bus2;
  tri1  [31:0] bus0;
  logic        cs2, cs0, rdy2, rdy0, err2, err0;
  logic        rdy, err;
  logic [31:0] bus_v;

  int tests = 0;
  int fails = 0;

  exp_t       sb_q[$];
  logic [7:0] model2 [int];
  logic [7:0] model0 [int];

  always #5 clk = ~clk;

  assign bus2  = tb_oe ? tb_dout : 'z;
  assign bus0  = tb_oe ? tb_dout : 'z;
  assign cs2   = cs & ~sel0;
  assign cs0   = cs & sel0;
  assign rdy   = sel0 ? rdy0 : rdy2;
  assign err   = sel0 ? err0 : err2;
  assign bus_v = sel0 ? bus0 : bus2;

  data_mem_resp #(.MEM_BYTES(4096), .WAIT_STATES(2)) u_dut (
    .Clk(clk), .Reset(rst_n), .dm_cs(cs2), .dm_rd(rd), .dm_wr(wr),
    .Mem_addr(addr), .Bus_data(bus2), .dm_rdy(rdy2), .dm_err(err2)
  );

  data_mem_resp #(.MEM_BYTES(4096), .WAIT_STATES(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .dm_cs(cs0), .dm_rd(rd), .dm_wr(wr),
    .Mem_addr(addr), .Bus_data(bus0), .dm_rdy(rdy0), .dm_err(err0)
  );

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (({1'b0, a} + 33'd3) >= 33'd4096);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[31-8*i -: 8] = sel0 ? model0[int'(a) + i] : model2[int'(a) + i];
    return w;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (sel0) model0[int'(a) + i] = d[31-8*i -: 8];
      else      model2[int'(a) + i] = d[31-8*i -: 8];
    end
  endtask

  // One complete request; starts and ends 1 time unit after a rising edge.
  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    logic got;
    e.is_rd = r & ~w;
    e.err   = (r & w) | bad_addr(a);
    e.lat   = ((r & w) | sel0) ? 0 : 2;
    e.data  = 32'h0;
    if (e.is_rd && !e.err) e.data = model_rd(a);
    if (w && !r && !e.err) model_wr(a, d);
    sb_q.push_back(e);

    cs = 1'b1; rd = r; wr = w; addr = a; tb_dout = d; tb_oe = w;
    @(posedge clk); #1;
    addr = $urandom;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      tests++;
      if (err !== 1'b0) begin
        fails++;
        $display("FAIL err_without_rdy addr=%h actual=%b required=0", a, err);
      end
      @(posedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL rdy_timeout addr=%h no dm_rdy within 20 cycles", a);
    end else begin
      if (lat != e.lat) begin
        fails++;
        $display("FAIL rdy_latency addr=%h actual=%0d required=%0d edges", a, lat + 1, e.lat + 1);
      end
      tests++;
      if (err !== e.err) begin
        fails++;
        $display("FAIL dm_err addr=%h actual=%b required=%b", a, err, e.err);
      end
      if (e.is_rd) begin
        tests++;
        if (bus_v !== e.data) begin
          fails++;
          $display("FAIL read_data addr=%h actual=%h required=%h", a, bus_v, e.data);
        end
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (e.is_rd) begin
        tests++;
        if (bus_v !== e.data) begin
          fails++;
          $display("FAIL hold_data addr=%h actual=%h required=%h", a, bus_v, e.data);
        end
      end
    end
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_v !== HIZ || rdy !== 1'b0) begin
      fails++;
      $display("FAIL release addr=%h bus actual=%h required=%h rdy=%b", a, bus_v, HIZ, rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (rdy2 !== 1'b0 || err2 !== 1'b0 || bus2 !== HIZ) begin
      fails++;
      $display("FAIL %s rdy=%b err=%b bus=%h required rdy=0 err=0 bus=%h", tag, rdy2, err2, bus2, HIZ);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_w2");
    tests++;
    if (rdy0 !== 1'b0 || err0 !== 1'b0 || bus0 !== HIZ) begin
      fails++;
      $display("FAIL reset_w0 rdy=%b err=%b bus=%h required rdy=0 err=0 bus=%h", rdy0, err0, bus0, HIZ);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    tests++;
    if (u_dut.u_array.mem_q[16] !== 8'hDE) begin
      fails++;
      $display("FAIL byte_order actual=%h required=de", u_dut.u_array.mem_q[16]);
    end
  endtask

  task automatic test_zero_wait();
    sel0 = 1'b1;
    issue(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 32'h40, 32'h0);
    sel0 = 1'b0;
  endtask

  task automatic test_errors();
    issue(1'b0, 1'b1, 32'h0,   32'h0102_0304);
    issue(1'b0, 1'b1, 32'h12,  32'h1122_3344);
    issue(1'b1, 1'b0, 32'h10,  32'h0);
    issue(1'b1, 1'b0, 32'h12,  32'h0);
    issue(1'b0, 1'b1, 32'hFFC, 32'hA5A5_0FF0);
    issue(1'b1, 1'b0, 32'hFFC, 32'h0);
    issue(1'b0, 1'b1, 32'h1000, 32'h9999_9999);
    issue(1'b1, 1'b0, 32'h1000, 32'h0);
    issue(1'b1, 1'b0, 32'h0,   32'h0);
    issue(1'b1, 1'b0, 32'hFFC, 32'h0);
  endtask

  task automatic test_abort();
    issue(1'b0, 1'b1, 32'h20, 32'hAAAA_5555);
    cs = 1'b1; wr = 1'b1; addr = 32'h20; tb_dout = 32'h1234_5678; tb_oe = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; tb_oe = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (rdy2 !== 1'b0) begin
        fails++;
        $display("FAIL abort_rdy cycle=%0d actual=%b required=0", k, rdy2);
      end
    end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_reset_mid();
    cs = 1'b1; wr = 1'b1; addr = 32'h20; tb_dout = 32'h0BAD_F00D; tb_oe = 1'b1;
    @(posedge clk); #3;
    tb_oe = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    cs = 1'b0; wr = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h20, 32'h0);

    cs = 1'b1; rd = 1'b1; addr = 32'h10;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (rdy2 !== 1'b1 || bus2 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL pre_reset_xfer rdy=%b bus=%h required rdy=1 bus=deadbeef", rdy2, bus2);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_xfer_rd");
    cs = 1'b0; rd = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    cs = 1'b1; wr = 1'b1; addr = 32'h20; tb_dout = 32'hFEED_FACE; tb_oe = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (rdy2 !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_wr_xfer rdy actual=%b required=1", rdy2);
    end
    rst_n = 1'b0;
    tb_oe = 1'b0;
    #1;
    check_reset_outputs("reset_mid_xfer_wr");
    cs = 1'b0; wr = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_dual_strobe();
    issue(1'b1, 1'b1, 32'h10, 32'h5555_5555);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
      issue(1'b0, 1'b1, addrs[i], $urandom);
    end
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, addrs[i], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_abort();
    test_reset_mid();
    test_dual_strobe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter MEM_BYTES, default 4096, byte capacity of the memory array.
REQ-002 Parameter WAIT_STATES, default 2, wait cycles inserted before each transfer (0..15).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Clk  input  1  rising-edge clock shared with the execution unit.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 dm_cs  input  1  chip select; high for the whole duration of a request.
REQ-007 dm_rd  input  1  read strobe, qualified by dm_cs.
REQ-008 dm_wr  input  1  write strobe, qualified by dm_cs.
REQ-009 Mem_addr  input  32  byte address from the bus interface unit MAR.
REQ-010 Bus_data  inout  32  bidirectional data bus, driven by this block only for reads.
REQ-011 dm_rdy  output  1  transfer-complete strobe, one cycle wide.
REQ-012 dm_err  output  1  error qualifier, valid only while dm_rdy is high.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, XFER and HOLD.
REQ-014 IDLE->WAIT when dm_cs=1 and exactly one of dm_rd/dm_wr is 1; Mem_addr and direction are latched on this edge.
REQ-015 With WAIT_STATES=0, IDLE->XFER directly on the same edge.
REQ-016 WAIT SHALL count WAIT_STATES cycles and then move to XFER; dm_rdy rises WAIT_STATES+1 cycles after the request edge.
REQ-017 XFER SHALL last exactly one cycle with dm_rdy=1, then move to HOLD.
REQ-018 A write SHALL store Bus_data sampled in the XFER cycle, big-endian: [31:24] to addr, [7:0] to addr+3.
REQ-019 A read SHALL drive the big-endian word at the latched address on Bus_data in XFER, and in HOLD while dm_rd=1; otherwise Bus_data SHALL be high-Z.
REQ-020 HOLD->IDLE when dm_cs=0; a new request needs dm_cs to deassert for at least one cycle.
REQ-021 Mem_addr, dm_rd and dm_wr changes after the latch edge SHALL be ignored until IDLE.
REQ-022 dm_cs=0 during WAIT SHALL abort to IDLE: no write, no dm_rdy.
REQ-023 dm_cs=1 with dm_rd=dm_wr=1 SHALL go directly to XFER with dm_err=1 and SHALL NOT access memory.
REQ-024 Misaligned (addr[1:0]!=0) or out-of-range (addr+3 >= MEM_BYTES) requests SHALL complete normally with dm_err=1, no write, and read data 32'h0.
REQ-025 dm_err SHALL be 0 whenever dm_rdy=0.

Reset
REQ-026 Reset=0 SHALL force IDLE, dm_rdy=0, dm_err=0, Bus_data high-Z and wait counter 0, immediately and regardless of Clk.
REQ-027 A reset during WAIT or XFER SHALL leave memory contents unchanged by the aborted request.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-029 The FSM state encoding and the default MEM_BYTES/WAIT_STATES constants SHALL live in the shared package dmem_pkg.
REQ-030 The byte array SHALL be a sub-module dmem_array with a synchronous 32-bit big-endian write port and a combinational read port.
REQ-031 The FSM, wait counter, error decode and tri-state control SHALL reside in data_mem_resp.

Verification
REQ-032 Write 0xDEADBEEF at 0x10, then read 0x10 -> dm_rdy 3 cycles after each request edge; read returns 0xDEADBEEF; byte 0x10 = 0xDE.
REQ-033 Read with WAIT_STATES=0 -> dm_rdy on the cycle after the request edge; Bus_data high-Z once dm_cs and dm_rd drop.
REQ-034 Write to 0x12 -> dm_rdy=1 with dm_err=1; memory at 0x10..0x13 unchanged; read of 0x12 returns 0x00000000 with dm_err=1.
REQ-035 Drop dm_cs one cycle into WAIT of a write of 0x12345678 to 0x20 -> no dm_rdy; a later read of 0x20 returns the prior value.
REQ-036 Assert Reset low mid-WAIT of a write -> dm_rdy=0 and Bus_data high-Z asynchronously; after release, prior memory data is intact.
REQ-037 dm_rd=dm_wr=1 -> dm_rdy=1 and dm_err=1 on the next cycle; memory unchanged.
